// File: rtl/smc_pkg.sv
// Shared definitions for serial_mismatch_counter.
//   smc_state_e  : frame FSM state (idle / accumulating / holding a result)
//   FrameLenMin  : smallest legal FRAME_LEN
//   FrameLenMax  : largest legal FRAME_LEN
package smc_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } smc_state_e;

  localparam int unsigned FrameLenMin = 2;
  localparam int unsigned FrameLenMax = 255;

endpackage

// File: rtl/bit_cmp_cell.sv
// Per-beat bit comparator: classifies one a/b pair.
// Ports:
//   a   : reference bit
//   b   : received bit
//   mis : 1 when a != b (XOR)
//   eq  : 1 when a == b (XNOR)
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic mis,
  output logic eq
);

  assign mis = a ^ b;
  assign eq  = ~(a ^ b);

endmodule

// File: rtl/serial_mismatch_counter.sv
// Bit-serial mismatch counter: accepts FRAME_LEN a/b pairs over a valid/ready input,
// counts mismatching beats and presents one result word over a valid/ready output.
// Optional feature: define SMC_STICKY_ERR_EN to add the err_sticky output and clr input.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake for one bit pair (a, b)
//   out_valid/out_ready : output handshake for the frame result
//   mis_cnt             : mismatching beats in the frame
//   frame_eq            : 1 when mis_cnt == 0
//   parity              : XOR of all a^b in the frame (mis_cnt[0])
//   err_sticky, clr     : (SMC_STICKY_ERR_EN) sticky error flag and its clear
module serial_mismatch_counter #(
  parameter  int unsigned FRAME_LEN = 16,
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
`ifdef SMC_STICKY_ERR_EN
  output logic             err_sticky,
  input  logic             clr,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] mis_cnt,
  output logic             frame_eq,
  output logic             parity
);

  import smc_pkg::*;

  if (FRAME_LEN < FrameLenMin || FRAME_LEN > FrameLenMax) begin : g_bad_frame_len
    $error("serial_mismatch_counter: FRAME_LEN out of range");
  end

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(FRAME_LEN - 1);

  smc_state_e       state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic             enter_hold;

  logic cmp_mis, cmp_eq, mis_bit;

  bit_cmp_cell u_bit_cmp_cell (
    .a   (a),
    .b   (b),
    .mis (cmp_mis),
    .eq  (cmp_eq)
  );

  // The cell's rails are complementary; counting only when both agree keeps a
  // stuck rail from silently inflating the count.
  assign mis_bit = cmp_mis & ~cmp_eq;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    acc_d      = acc_q;
    res_d      = res_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    enter_hold = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = CNT_W'(mis_bit);
          beat_d  = CNT_W'(1);
          state_d = StRun;
        end
      end
      StRun: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (beat_q == LastBeat) begin
            res_d      = acc_q + CNT_W'(mis_bit);
            acc_d      = '0;
            beat_d     = '0;
            state_d    = StHold;
            enter_hold = 1'b1;
          end else begin
            acc_d  = acc_q + CNT_W'(mis_bit);
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      StHold: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign mis_cnt  = res_q;
  assign frame_eq = (res_q == '0);
  assign parity   = res_q[0];

`ifdef SMC_STICKY_ERR_EN
  logic err_q, err_d;

  // Set has priority over clear so a failing frame is never lost to a clr.
  always_comb begin
    err_d = err_q;
    if (clr) begin
      err_d = 1'b0;
    end
    if (enter_hold && (res_d != '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule
